// File: rtl/writeback_arbiter.sv
// Two-requester write-back arbiter: round-robin between ALU (0) and memory (1) results,
// with bounded lock bursts, driving a registered register-file write port and mux select.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  sel,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  // A lock may be extended only while the counter is below this value.
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic [CW-1:0] burst_cnt, cnt_nxt, base_cnt;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state == OWN0 && req0) begin
        gnt0 = 1'b1;
      end else if (state == OWN1 && req1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        // Tie: the requester that was not served last wins.
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    // The counter only continues when the current owner is granted again.
    base_cnt  = ((gnt0 && state == OWN0) || (gnt1 && state == OWN1)) ? burst_cnt : '0;
    if (gnt0 && lock0 && base_cnt < CAP) begin
      state_nxt = OWN0;
      cnt_nxt   = base_cnt + CW'(1);
    end else if (gnt1 && lock1 && base_cnt < CAP) begin
      state_nxt = OWN1;
      cnt_nxt   = base_cnt + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      sel       <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      busy      <= (state_nxt != IDLE);
      wr_en     <= gnt0 | gnt1;
      if (gnt0) begin
        last    <= 1'b0;
        sel     <= 1'b0;
        wr_data <= data0;
        wr_addr <= addr0;
      end else if (gnt1) begin
        last    <= 1'b1;
        sel     <= 1'b1;
        wr_data <= data1;
        wr_addr <= addr1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (MAX_BURST=4): reset, single beat,
// round-robin, lock burst cap, lock release without bubble, reset mid-burst.
module tb_writeback_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, lock0, req1, lock1;
  logic [7:0] data0, data1;
  logic [2:0] addr0, addr1;
  logic       gnt0, gnt1, sel, wr_en, busy;
  logic [7:0] wr_data;
  logic [2:0] wr_addr;

  int passed = 0;
  int total  = 0;

  writeback_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .data0(data0), .addr0(addr0),
    .req1(req1), .lock1(lock1), .data1(data1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .wr_en(wr_en),
    .wr_data(wr_data), .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are valid then too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b1; lock0 = 1'b0; req1 = 1'b1; lock1 = 1'b0;
    data0 = 8'h00; addr0 = 3'd0; data1 = 8'h00; addr1 = 3'd0;

    // 1. Reset held two cycles with both requesting.
    #2;
    check("rst_gnt0_c1", gnt0, 0);
    check("rst_gnt1_c1", gnt1, 0);
    tick();
    check("rst_gnt0_c2", gnt0, 0);
    check("rst_gnt1_c2", gnt1, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_data", wr_data, 0);
    tick();
    reset = 1'b0;

    // 2. Single beat from requester 0.
    req0 = 1'b1; req1 = 1'b0; data0 = 8'hA5; addr0 = 3'd3;
    #1;
    check("single_gnt0", gnt0, 1);
    check("single_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0;
    check("single_wr_en", wr_en, 1);
    check("single_wr_data", wr_data, 8'hA5);
    check("single_wr_addr", wr_addr, 3);
    check("single_sel", sel, 0);
    #1;
    check("single_idle_gnt0", gnt0, 0);
    tick();
    check("single_wr_en_off", wr_en, 0);
    check("single_data_hold", wr_data, 8'hA5);

    // 3. Round-robin with both requesting, no locks.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; addr0 = 3'd1; data1 = 8'h22; addr1 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", gnt1, (i % 2 == 0) ? 0 : 1);
      tick();
      check("rr_sel", sel, (i % 2 == 0) ? 0 : 1);
      check("rr_wr_data", wr_data, (i % 2 == 0) ? 8'h11 : 8'h22);
    end

    // 4. Locked burst from requester 0 capped at 4 beats, then requester 1.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("burst_gnt0", gnt0, 1);
      check("burst_gnt1", gnt1, 0);
      tick();
      check("burst_busy", busy, (i < 3) ? 1 : 0);
    end
    #1;
    check("burst_after_gnt0", gnt0, 0);
    check("burst_after_gnt1", gnt1, 1);
    tick();
    check("burst_after_sel", sel, 1);
    check("burst_after_busy", busy, 0);

    // 5. Owner drops its request: other requester granted in the same cycle.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b0; lock1 = 1'b0;
    tick();
    check("release_busy_own", busy, 1);
    req0 = 1'b0; req1 = 1'b1;
    #1;
    check("release_gnt0", gnt0, 0);
    check("release_gnt1", gnt1, 1);
    tick();
    check("release_busy", busy, 0);
    check("release_sel", sel, 1);

    // 6. Reset on the second beat of a locked burst.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; lock1 = 1'b0; data0 = 8'h55; addr0 = 3'd5;
    tick();
    check("midrst_busy_before", busy, 1);
    check("midrst_wr_en_before", wr_en, 1);
    reset = 1'b1; data0 = 8'h66; addr0 = 3'd6;
    #1;
    check("midrst_gnt0", gnt0, 0);
    check("midrst_gnt1", gnt1, 0);
    tick();
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wr_data", wr_data, 0);
    reset = 1'b0; lock0 = 1'b0;
    #1;
    check("midrst_first_gnt0", gnt0, 1);
    check("midrst_first_gnt1", gnt1, 0);
    tick();
    check("midrst_first_sel", sel, 0);
    check("midrst_first_data", wr_data, 8'h66);
    check("midrst_first_addr", wr_addr, 6);

    req0 = 1'b0; req1 = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
